// File: rtl/dual_port_ram.sv
// -----------------------------------------------------------------------------
// dual_port_ram
//
// True dual-port RAM: two fully independent read/write ports (A and B) share
// one 2**ADDR_WIDTH x DATA_WIDTH array. Both ports use a single clock, and both
// read outputs are registered, so read latency is exactly one cycle.
//
// Parameters
//   DATA_WIDTH    word width in bits (default 8)
//   ADDR_WIDTH    address width; depth = 2**ADDR_WIDTH (default 6 -> 64 words)
//
// Ports
//   clk            in   single clock, rising edge
//   rst            in   asynchronous active-high reset; clears the read
//                       registers and blocks writes. Memory is not cleared.
//   input_data_a   in   port A write data
//   address_a      in   port A word address
//   we_a           in   port A write enable
//   output_data_a  out  port A registered read data
//   input_data_b   in   port B write data
//   address_b      in   port B word address
//   we_b           in   port B write enable
//   output_data_b  out  port B registered read data
//
// Configuration
//   DUAL_PORT_RAM_WRITE_FIRST_EN  when defined, each port is write-first: a
//       written word (from either port) appears on the read output of any
//       port addressing it on the same edge, with port A data winning when
//       both ports write the same address. When undefined, reads are
//       read-first and always return the contents from before the edge.
//
// Collision rule: when both ports write the same address on one edge, port A
// data is stored and port B data is discarded.
// -----------------------------------------------------------------------------
module dual_port_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] input_data_a,
    input  logic [ADDR_WIDTH-1:0] address_a,
    input  logic                  we_a,
    output logic [DATA_WIDTH-1:0] output_data_a,
    input  logic [DATA_WIDTH-1:0] input_data_b,
    input  logic [ADDR_WIDTH-1:0] address_b,
    input  logic                  we_b,
    output logic [DATA_WIDTH-1:0] output_data_b
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [DATA_WIDTH-1:0] rd_a_q, rd_a_d;
    logic [DATA_WIDTH-1:0] rd_b_q, rd_b_d;

    logic same_addr;
    logic we_b_eff;

    assign same_addr = (address_a == address_b);
    // Port B loses a same-address collision, so its write is dropped there.
    assign we_b_eff  = we_b && !(we_a && same_addr);

    // Memory array has no reset; contents survive rst. Writes are gated by
    // rst so nothing is stored while reset is held.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (we_a) begin
                mem_q[address_a] <= input_data_a;
            end
            if (we_b_eff) begin
                mem_q[address_b] <= input_data_b;
            end
        end
    end

`ifdef DUAL_PORT_RAM_WRITE_FIRST_EN
    // Write-first: forward the data being stored this edge to any port that
    // addresses it. Port A has priority, matching what the array keeps.
    always_comb begin
        rd_a_d = mem_q[address_a];
        if (we_a) begin
            rd_a_d = input_data_a;
        end else if (we_b && same_addr) begin
            rd_a_d = input_data_b;
        end
    end

    always_comb begin
        rd_b_d = mem_q[address_b];
        if (we_a && same_addr) begin
            rd_b_d = input_data_a;
        end else if (we_b) begin
            rd_b_d = input_data_b;
        end
    end
`else
    // Read-first: outputs always see the contents from before this edge.
    always_comb begin
        rd_a_d = mem_q[address_a];
        rd_b_d = mem_q[address_b];
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_a_q <= '0;
            rd_b_q <= '0;
        end else begin
            rd_a_q <= rd_a_d;
            rd_b_q <= rd_b_d;
        end
    end

    assign output_data_a = rd_a_q;
    assign output_data_b = rd_b_q;

endmodule

// File: tb/tb_dual_port_ram.sv
// -----------------------------------------------------------------------------
// tb_dual_port_ram
//
// Directed bench for dual_port_ram. The stimulus process drives one vector per
// cycle on the falling edge and pushes that vector's expected read data into a
// scoreboard queue; the monitor pops one entry shortly after each rising edge
// and compares it against the registered outputs. Reset behaviour is checked
// directly around the reset pulse.
// -----------------------------------------------------------------------------
module tb_dual_port_ram;

    localparam int DW = 8;
    localparam int AW = 6;

    logic          clk;
    logic          rst;
    logic [DW-1:0] input_data_a, input_data_b;
    logic [AW-1:0] address_a, address_b;
    logic          we_a, we_b;
    logic [DW-1:0] output_data_a, output_data_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit            chk_a;
        logic [DW-1:0] exp_a;
        bit            chk_b;
        logic [DW-1:0] exp_b;
        string         name;
    } sb_entry_t;

    sb_entry_t sb[$];

    dual_port_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .input_data_a  (input_data_a),
        .address_a     (address_a),
        .we_a          (we_a),
        .output_data_a (output_data_a),
        .input_data_b  (input_data_b),
        .address_b     (address_b),
        .we_b          (we_b),
        .output_data_b (output_data_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: one scoreboard entry per rising edge that followed a vector.
    initial begin
        sb_entry_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.chk_a) check({e.name, " port A"}, output_data_a, e.exp_a);
                if (e.chk_b) check({e.name, " port B"}, output_data_b, e.exp_b);
            end
        end
    end

    task automatic vec(input bit wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                       input bit wb, input logic [AW-1:0] ab, input logic [DW-1:0] db,
                       input bit ca, input logic [DW-1:0] ea,
                       input bit cb, input logic [DW-1:0] eb,
                       input string name);
        sb_entry_t e;
        @(negedge clk);
        we_a = wa; address_a = aa; input_data_a = da;
        we_b = wb; address_b = ab; input_data_b = db;
        e.chk_a = ca; e.exp_a = ea; e.chk_b = cb; e.exp_b = eb; e.name = name;
        sb.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        we_a = 1'b0;
        we_b = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit drained;
        rst = 1'b1;
        we_a = 1'b0; we_b = 1'b0;
        address_a = '0; address_b = '0;
        input_data_a = '0; input_data_b = '0;
        #1;
        check("reset initial A", output_data_a, 8'h00);
        check("reset initial B", output_data_b, 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        vec(1, 6'd3, 8'h5A, 0, 6'd0, 8'h00, 0, 8'h00, 0, 8'h00, "write 5A@3");
        vec(0, 6'd3, 8'h00, 0, 6'd3, 8'h00, 1, 8'h5A, 1, 8'h5A, "read 3 before reset");
        idle();

        // Mid-run reset with a write attempt that must be blocked.
        @(negedge clk);
        rst = 1'b1;
        we_a = 1'b1; address_a = 6'd3; input_data_a = 8'hFF;
        #1;
        check("async reset A", output_data_a, 8'h00);
        check("async reset B", output_data_b, 8'h00);
        @(posedge clk);
        #1;
        check("reset held A", output_data_a, 8'h00);
        check("reset held B", output_data_b, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        we_a = 1'b0;

        vec(0, 6'd3, 8'h00, 0, 6'd3, 8'h00, 1, 8'h5A, 1, 8'h5A, "read 3 after reset");
        vec(1, 6'd7, 8'hAA, 0, 6'd3, 8'h00, 0, 8'h00, 1, 8'h5A, "A write AA@7");
        vec(0, 6'd7, 8'h00, 0, 6'd7, 8'h00, 1, 8'hAA, 1, 8'hAA, "read 7");
        vec(1, 6'd20, 8'h11, 1, 6'd30, 8'h22, 0, 8'h00, 0, 8'h00, "split write 20/30");
        vec(0, 6'd30, 8'h00, 0, 6'd20, 8'h00, 1, 8'h22, 1, 8'h11, "cross read 30/20");
`ifdef DUAL_PORT_RAM_WRITE_FIRST_EN
        vec(1, 6'd63, 8'h33, 1, 6'd63, 8'h44, 1, 8'h33, 1, 8'h33, "collide 63");
`else
        vec(1, 6'd63, 8'h33, 1, 6'd63, 8'h44, 0, 8'h00, 0, 8'h00, "collide 63");
`endif
        vec(0, 6'd63, 8'h00, 0, 6'd63, 8'h00, 1, 8'h33, 1, 8'h33, "read 63 after collide");
        vec(1, 6'd0, 8'h01, 0, 6'd63, 8'h00, 0, 8'h00, 1, 8'h33, "write 01@0");
`ifdef DUAL_PORT_RAM_WRITE_FIRST_EN
        vec(1, 6'd0, 8'h02, 0, 6'd0, 8'h00, 1, 8'h02, 1, 8'h02, "write 02@0 with B read");
`else
        vec(1, 6'd0, 8'h02, 0, 6'd0, 8'h00, 1, 8'h01, 1, 8'h01, "write 02@0 with B read");
`endif
        vec(0, 6'd0, 8'h00, 0, 6'd0, 8'h00, 1, 8'h02, 1, 8'h02, "read 0");
`ifdef DUAL_PORT_RAM_WRITE_FIRST_EN
        vec(1, 6'd0, 8'hF0, 1, 6'd63, 8'h0F, 1, 8'hF0, 1, 8'h0F, "write F0@0 0F@63");
`else
        vec(1, 6'd0, 8'hF0, 1, 6'd63, 8'h0F, 1, 8'h02, 1, 8'h33, "write F0@0 0F@63");
`endif
        vec(0, 6'd63, 8'h00, 0, 6'd0, 8'h00, 1, 8'h0F, 1, 8'hF0, "read 63/0 no alias");
        vec(0, 6'd0, 8'h00, 1, 6'd5, 8'h66, 1, 8'hF0, 0, 8'h00, "B write 66@5");
`ifdef DUAL_PORT_RAM_WRITE_FIRST_EN
        vec(0, 6'd5, 8'h00, 1, 6'd5, 8'h77, 1, 8'h77, 1, 8'h77, "B write 77@5 A read");
`else
        vec(0, 6'd5, 8'h00, 1, 6'd5, 8'h77, 1, 8'h66, 1, 8'h66, "B write 77@5 A read");
`endif
        vec(0, 6'd5, 8'h00, 0, 6'd5, 8'h00, 1, 8'h77, 1, 8'h77, "read 5");
        idle();

        drained = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (sb.size() == 0) begin
                drained = 1'b1;
                break;
            end
        end
        if (!drained) begin
            errors++;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dual_port_ram.md
DUAL_PORT_RAM -- requirements
Module: dual_port_ram

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 6, SHALL set the address width; depth SHALL be 2**ADDR_WIDTH (64).
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge except reset.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 input_data_a  input  DATA_WIDTH  SHALL be the port A write data.
REQ-006 address_a  input  ADDR_WIDTH  SHALL be the port A word address.
REQ-007 we_a  input  1  SHALL be the port A write enable, active high.
REQ-008 output_data_a  output  DATA_WIDTH  SHALL be the port A registered read data.
REQ-009 input_data_b  input  DATA_WIDTH  SHALL be the port B write data.
REQ-010 address_b  input  ADDR_WIDTH  SHALL be the port B word address.
REQ-011 we_b  input  1  SHALL be the port B write enable, active high.
REQ-012 output_data_b  output  DATA_WIDTH  SHALL be the port B registered read data.

Function
REQ-013 Both ports SHALL be fully independent read/write ports sharing one 2**ADDR_WIDTH x DATA_WIDTH array.
REQ-014 On a rising edge with we_x=1, mem[address_x] SHALL take input_data_x.
REQ-015 On every rising edge, output_data_x SHALL load mem[address_x] as sampled at that edge: read latency is exactly 1 cycle and the output holds between edges.
REQ-016 A read on one port SHALL see data written by either port on any earlier edge.
REQ-017 Without the REQ-024 macro, reads SHALL be read-first: a port writing an address returns the old contents that cycle, and a cross-port read of an address written in the same cycle returns the old contents.
REQ-018 If both ports write the same address on the same edge, port A data SHALL be stored and port B data discarded.
REQ-019 Writes to different addresses on the same edge SHALL both be stored.
REQ-020 Addresses SHALL cover the full range 0..2**ADDR_WIDTH-1 with no wrap or aliasing; there are no out-of-range addresses.

Reset
REQ-021 While rst=1, output_data_a and output_data_b SHALL be 0 immediately (asynchronous), and writes SHALL be suppressed.
REQ-022 Memory contents SHALL NOT be cleared by reset; contents before the first write are undefined (X in simulation).
REQ-023 After rst deasserts, the first rising edge SHALL perform normal read/write operation.

Configuration
REQ-024 Macro DUAL_PORT_RAM_WRITE_FIRST_EN, when defined, SHALL make each port write-first: on a write edge, output_data_x SHALL show the newly written data. A port reading an address written by the other port on the same edge SHALL return the new data, with port A data winning if both ports write that address. When the macro is undefined, REQ-017 read-first behaviour SHALL apply.

Verification
REQ-025 rst pulse mid-run -> both outputs 0 immediately; a prior write of 0x5A to address 3 is still readable as 0x5A after reset.
REQ-026 Port A writes 0xAA to address 7, then port B reads address 7 -> output_data_b=0xAA one cycle after the address is applied.
REQ-027 Same edge: A writes 0x11 to address 20, B writes 0x22 to address 30; then A reads 30 and B reads 20 -> output_data_a=0x22, output_data_b=0x11.
REQ-028 Same edge: A writes 0x33 and B writes 0x44, both to address 63 -> a later read of address 63 returns 0x33.
REQ-029 Address 0 holds 0x01; A writes 0x02 there while B reads address 0 on the same edge -> output_data_b=0x01 without the macro, 0x02 with DUAL_PORT_RAM_WRITE_FIRST_EN; output_data_a behaves the same way.
REQ-030 Write 0xF0 to address 0 and 0x0F to address 63 -> reading each address returns its own value with no aliasing.
